// File: rtl/apb_slave_regbank.sv
// APB responder: word-addressed 32-bit register bank with programmable wait states.
// Ports: Hclk/Hreset (sync, active-high), APB Psel/Penable/Pwrite/Paddr/Pwdata in,
// Prdata/Pready/Pslverr out. Define APB_SLVERR_EN to drive Pslverr on out-of-range
// accesses; otherwise Pslverr is tied 0.
module apb_slave_regbank #(
  parameter int SEL_BIT     = 0,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [2:0]  Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            oor_q, oor_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     prdata_q, prdata_d;
  logic [31:0]     mem_q [DEPTH];
  logic            mem_we;

  logic            sel;
  logic [AW-1:0]   idx;
  logic            oor;
  logic            ready;

  assign sel = Psel[SEL_BIT];
  assign idx = Paddr[AW+1:2];
  assign oor = (Paddr[31:2] >= 30'(DEPTH));

  logic unused_ok;
  assign unused_ok = ^{Paddr[1:0], Psel};

  // Ready only depends on registered state.
  assign ready = (state_q != S_ACCESS) || (wcnt_q == 4'd0);

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    oor_d    = oor_q;
    wdata_d  = wdata_q;
    prdata_d = prdata_q;
    mem_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // sel with Penable already high is a protocol error: ignored.
        if (sel && !Penable) begin
          state_d = S_SETUP;
          wr_d    = Pwrite;
          idx_d   = idx;
          oor_d   = oor;
          wdata_d = Pwdata;
          wcnt_d  = WS_INIT;
          if (!Pwrite) begin
            prdata_d = oor ? 32'd0 : mem_q[idx];
          end
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (!sel || !Penable) begin
          state_d = S_IDLE;
          wcnt_d  = 4'd0;
        end else if (wcnt_q == 4'd0) begin
          state_d = S_IDLE;
          mem_we  = wr_q && !oor_q;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q  <= S_IDLE;
      wcnt_q   <= 4'd0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      oor_q    <= 1'b0;
      wdata_q  <= 32'd0;
      prdata_q <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      oor_q    <= oor_d;
      wdata_q  <= wdata_d;
      prdata_q <= prdata_d;
      if (mem_we) begin
        mem_q[idx_q] <= wdata_q;
      end
    end
  end

  assign Prdata = prdata_q;
  assign Pready = ready;

`ifdef APB_SLVERR_EN
  assign Pslverr = (state_q == S_ACCESS) && ready && oor_q;
`else
  assign Pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench: three responders on Psel[0..2] with 0, 2 and 3 wait states.
// Exercises write/read, wait states, out-of-range, deselect, abort and reset.
module tb_apb_slave_regbank;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic [2:0]  Psel;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] prdata0, prdata1, prdata2;
  logic        pready0, pready1, pready2;
  logic        pslverr0, pslverr1, pslverr2;

  int checks = 0;
  int errors = 0;

`ifdef APB_SLVERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 Hclk = ~Hclk;

  apb_slave_regbank #(.SEL_BIT(0), .DEPTH(16), .WAIT_STATES(0)) u0 (
    .Hclk(Hclk), .Hreset(Hreset), .Psel(Psel), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata(prdata0), .Pready(pready0), .Pslverr(pslverr0));

  apb_slave_regbank #(.SEL_BIT(1), .DEPTH(16), .WAIT_STATES(2)) u1 (
    .Hclk(Hclk), .Hreset(Hreset), .Psel(Psel), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata(prdata1), .Pready(pready1), .Pslverr(pslverr1));

  apb_slave_regbank #(.SEL_BIT(2), .DEPTH(16), .WAIT_STATES(3)) u2 (
    .Hclk(Hclk), .Hreset(Hreset), .Psel(Psel), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata(prdata2), .Pready(pready2), .Pslverr(pslverr2));

  function automatic logic [31:0] rd_of(input int s);
    case (s)
      0: return prdata0;
      1: return prdata1;
      default: return prdata2;
    endcase
  endfunction

  function automatic logic rdy_of(input int s);
    case (s)
      0: return pready0;
      1: return pready1;
      default: return pready2;
    endcase
  endfunction

  function automatic logic err_of(input int s);
    case (s)
      0: return pslverr0;
      1: return pslverr1;
      default: return pslverr2;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the completion edge
  // with the bus idle, so a following call is a back-to-back setup.
  task automatic xfer(input int s, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input int nw,
                      output logic [31:0] rd, output int low_cnt,
                      output logic err, output logic stable);
    Psel = 3'(1 << s);
    Penable = 1'b0;
    Pwrite = wr;
    Paddr = a;
    Pwdata = d;
    @(negedge Hclk);
    Penable = 1'b1;
    rd = rd_of(s);
    low_cnt = 0;
    err = 1'b0;
    stable = 1'b1;
    for (int i = 0; i <= nw; i++) begin
      @(negedge Hclk);
      if (!rdy_of(s)) low_cnt++;
      else err = err_of(s);
      if (rd_of(s) !== rd) stable = 1'b0;
    end
    @(negedge Hclk);
    Psel = 3'b000;
    Penable = 1'b0;
    if (rd_of(s) !== rd) stable = 1'b0;
  endtask

  task automatic test_reset();
    Hreset = 1'b1;
    Psel = 3'b000;
    Penable = 1'b0;
    Pwrite = 1'b0;
    Paddr = 32'd0;
    Pwdata = 32'd0;
    repeat (3) @(negedge Hclk);
    Hreset = 1'b0;
    @(negedge Hclk);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (rdy_of(s) !== 1'b1) begin
        errors++;
        $display("FAIL reset_pready[%0d]: got %b want 1", s, rdy_of(s));
      end
      checks++;
      if (rd_of(s) !== 32'd0) begin
        errors++;
        $display("FAIL reset_prdata[%0d]: got %h want 0", s, rd_of(s));
      end
      checks++;
      if (err_of(s) !== 1'b0) begin
        errors++;
        $display("FAIL reset_pslverr[%0d]: got %b want 0", s, err_of(s));
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    int lo;
    logic er, st;
    xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 0, rd, lo, er, st);
    checks++;
    if (lo !== 0 || er !== 1'b0) begin
      errors++;
      $display("FAIL basic_wr: low=%0d err=%b want 0/0", lo, er);
    end
    xfer(0, 1'b0, 32'h08, 32'h0, 0, rd, lo, er, st);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_rd: got %h want deadbeef", rd);
    end
    checks++;
    if (lo !== 0 || er !== 1'b0 || st !== 1'b1) begin
      errors++;
      $display("FAIL basic_rd_hs: low=%0d err=%b stable=%b want 0/0/1",
               lo, er, st);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    int lo;
    logic er, st;
    xfer(1, 1'b1, 32'h04, 32'h0BADF00D, 2, rd, lo, er, st);
    checks++;
    if (lo !== 2) begin
      errors++;
      $display("FAIL ws_wr_low: got %0d want 2", lo);
    end
    xfer(1, 1'b0, 32'h04, 32'h0, 2, rd, lo, er, st);
    checks++;
    if (lo !== 2) begin
      errors++;
      $display("FAIL ws_rd_low: got %0d want 2", lo);
    end
    checks++;
    if (rd !== 32'h0BADF00D || st !== 1'b1) begin
      errors++;
      $display("FAIL ws_rd_data: got %h stable=%b want 0badf00d/1", rd, st);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    int lo;
    logic er, st;
    xfer(0, 1'b1, 32'h00, 32'hCAFEF00D, 0, rd, lo, er, st);
    xfer(0, 1'b1, 32'h40, 32'h12345678, 0, rd, lo, er, st);
    checks++;
    if (er !== EXP_ERR) begin
      errors++;
      $display("FAIL oor_wr_err: got %b want %b", er, EXP_ERR);
    end
    xfer(0, 1'b0, 32'h00, 32'h0, 0, rd, lo, er, st);
    checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      errors++;
      $display("FAIL oor_rd0: got %h err=%b want cafef00d/0", rd, er);
    end
    xfer(0, 1'b0, 32'h40, 32'h0, 0, rd, lo, er, st);
    checks++;
    if (rd !== 32'd0 || er !== EXP_ERR) begin
      errors++;
      $display("FAIL oor_rd40: got %h err=%b want 0/%b", rd, er, EXP_ERR);
    end
  endtask

  task automatic test_unselected();
    logic [31:0] rd;
    int lo;
    logic er, st;
    xfer(1, 1'b1, 32'h00, 32'hA5A5A5A5, 2, rd, lo, er, st);
    xfer(0, 1'b0, 32'h00, 32'h0, 0, rd, lo, er, st);
    checks++;
    if (rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL unsel_u0: got %h want cafef00d", rd);
    end
    xfer(1, 1'b0, 32'h00, 32'h0, 2, rd, lo, er, st);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL unsel_u1: got %h want a5a5a5a5", rd);
    end
    Psel = 3'b001;
    Penable = 1'b1;
    Pwrite = 1'b1;
    Paddr = 32'h00;
    Pwdata = 32'h00000BAD;
    repeat (2) @(negedge Hclk);
    Psel = 3'b000;
    Penable = 1'b0;
    @(negedge Hclk);
    xfer(0, 1'b0, 32'h00, 32'h0, 0, rd, lo, er, st);
    checks++;
    if (rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL idle_penable: got %h want cafef00d", rd);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    int lo;
    logic er, st;
    xfer(2, 1'b1, 32'h0C, 32'h77, 3, rd, lo, er, st);
    checks++;
    if (lo !== 3) begin
      errors++;
      $display("FAIL abort_pre_low: got %0d want 3", lo);
    end
    Psel = 3'b100;
    Penable = 1'b0;
    Pwrite = 1'b1;
    Paddr = 32'h0C;
    Pwdata = 32'h11;
    @(negedge Hclk);
    Penable = 1'b1;
    @(negedge Hclk);
    @(negedge Hclk);
    Psel = 3'b000;
    @(negedge Hclk);
    Penable = 1'b0;
    checks++;
    if (pready2 !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: pready got %b want 1", pready2);
    end
    xfer(2, 1'b0, 32'h0C, 32'h0, 3, rd, lo, er, st);
    checks++;
    if (rd !== 32'h77) begin
      errors++;
      $display("FAIL abort_rd: got %h want 77", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int lo;
    logic er, st;
    xfer(0, 1'b1, 32'h14, 32'h01020304, 0, rd, lo, er, st);
    xfer(0, 1'b0, 32'h14, 32'h0, 0, rd, lo, er, st);
    checks++;
    if (rd !== 32'h01020304) begin
      errors++;
      $display("FAIL b2b_rd14: got %h want 01020304", rd);
    end
    xfer(1, 1'b1, 32'h3C, 32'hFEEDFACE, 2, rd, lo, er, st);
    xfer(1, 1'b0, 32'h3C, 32'h0, 2, rd, lo, er, st);
    checks++;
    if (rd !== 32'hFEEDFACE || lo !== 2) begin
      errors++;
      $display("FAIL b2b_rd3c: got %h low=%0d want feedface/2", rd, lo);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd;
    int lo;
    logic er, st;
    Psel = 3'b010;
    Penable = 1'b0;
    Pwrite = 1'b0;
    Paddr = 32'h04;
    @(negedge Hclk);
    Penable = 1'b1;
    checks++;
    if (prdata1 !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL rst_pre_rd: got %h want 0badf00d", prdata1);
    end
    @(negedge Hclk);
    Hreset = 1'b1;
    @(negedge Hclk);
    checks++;
    if (pready1 !== 1'b1 || prdata1 !== 32'd0 || pslverr1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: rdy=%b rd=%h err=%b want 1/0/0",
               pready1, prdata1, pslverr1);
    end
    Hreset = 1'b0;
    Psel = 3'b000;
    Penable = 1'b0;
    @(negedge Hclk);
    xfer(1, 1'b0, 32'h04, 32'h0, 2, rd, lo, er, st);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL rst_u1_04: got %h want 0", rd);
    end
    xfer(0, 1'b0, 32'h08, 32'h0, 0, rd, lo, er, st);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL rst_u0_08: got %h want 0", rd);
    end
    xfer(2, 1'b0, 32'h0C, 32'h0, 3, rd, lo, er, st);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL rst_u2_0c: got %h want 0", rd);
    end
  endtask

  initial begin
    @(negedge Hclk);
    test_reset();
    test_basic();
    test_wait_states();
    test_out_of_range();
    test_unselected();
    test_abort();
    test_back_to_back();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
